instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 88 ++++++++
 tb/tb_instr_fetch.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
//==============================================================================
// instr_fetch: PC generator feeding a small {pc, instr} FIFO toward decode.
// Revision: 1.0
//==============================================================================
`default_nettype none

module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] instr_rAddr,
   input  logic [31:0] instr_code,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic        misalign_err
);

   localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              CNT_W    = $clog2(DEPTH + 1);
   localparam logic [31:0]     NOP      = 32'h0000_0013;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [31:0]      pc;
   logic [CNT_W-1:0] count;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [31:0]      buf_pc    [DEPTH];
   logic [31:0]      buf_instr [DEPTH];
   logic             pop;
   logic             push;

   assign instr_rAddr = pc;
   assign pop         = id_valid & id_ready;
   // A pop frees a slot this same edge, so a full FIFO can still accept.
   assign push        = !redirect & ((count < FULL_CNT) | pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc           <= RESET_PC;
         count        <= '0;
         head         <= '0;
         tail         <= '0;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= redirect & (redirect_pc[1:0] != 2'b00);
         if (redirect) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            count <= '0;
            head  <= '0;
            tail  <= '0;
         end else begin
            if (push) begin
               pc   <= pc + 32'd4;
               tail <= tail + 1'b1;
            end
            if (pop) begin
               head <= head + 1'b1;
            end
            if (push && !pop) begin
               count <= count + 1'b1;
            end else if (!push && pop) begin
               count <= count - 1'b1;
            end
         end
      end
   end

   // Payload storage needs no reset: occupancy alone qualifies it.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc[tail]    <= pc;
         buf_instr[tail] <= instr_code;
      end
   end

   assign id_valid = (count != '0);
   assign id_instr = id_valid ? buf_instr[head] : NOP;
   assign id_pc    = id_valid ? buf_pc[head]    : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//==============================================================================
// tb_instr_fetch: directed scoreboard bench for instr_fetch.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_instr_fetch;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr_rAddr;
   logic [31:0] instr_code;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        misalign_err;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         32'h0000_0000: rom = 32'h0041_82B3;
         32'h0000_0004: rom = 32'h4094_03B3;
         default:       rom = {a[15:0], ~a[15:0]} ^ 32'h0513_0000;
      endcase
   endfunction

   assign instr_code = rom(instr_rAddr);

   instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .instr_rAddr  (instr_rAddr),
      .instr_code   (instr_code),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .id_ready     (id_ready),
      .id_valid     (id_valid),
      .id_instr     (id_instr),
      .id_pc        (id_pc),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_q.push_back('{pc: pc, instr: rom(pc)});
   endtask

   // Called with id_ready=1: the head shown now is consumed at the next edge.
   task automatic take_head(input string tag);
      exp_t e;
      check({tag, "_valid"}, 32'(id_valid), 32'd1);
      checks++;
      assert (exp_q.size() != 0) else begin
         errors++;
         $error("FAIL %s_extra observed=pc %h expected=no entry", tag, id_pc);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check({tag, "_pc"}, id_pc, e.pc);
         check({tag, "_instr"}, id_instr, e.instr);
      end
   endtask

   initial begin
      reset       = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      id_ready    = 1'b0;

      // Reset state
      #3;
      check("rst_valid", 32'(id_valid), 32'd0);
      check("rst_instr", id_instr, 32'h0000_0013);
      check("rst_pc", id_pc, 32'h0);
      check("rst_misalign", 32'(misalign_err), 32'd0);
      check("rst_addr", instr_rAddr, 32'h0);

      // Streaming: one per cycle from RESET_PC
      reset    = 1'b0;
      id_ready = 1'b1;
      push_exp(32'h0);
      push_exp(32'h4);
      tick();
      take_head("stream0");
      tick();
      take_head("stream1");

      // Back-pressure: fill, hold address, then drain in order
      reset    = 1'b1;
      id_ready = 1'b0;
      #2;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("bp_count", 32'(dut.count), 32'd2);
      check("bp_addr", instr_rAddr, 32'h8);
      check("bp_head", id_pc, 32'h0);
      push_exp(32'h0);
      push_exp(32'h4);
      push_exp(32'h8);
      id_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() == 0) break;
         if (id_valid) take_head("bp");
         tick();
      end
      check("bp_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      id_ready = 1'b0;
      tick();
      tick();
      check("full_count", 32'(dut.count), 32'd2);

      // Redirect while full
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      check("redir_valid", 32'(id_valid), 32'd0);
      check("redir_addr", instr_rAddr, 32'h40);
      check("redir_misalign", 32'(misalign_err), 32'd0);
      push_exp(32'h40);
      id_ready = 1'b1;
      tick();
      take_head("redir");

      // Misaligned target
      redirect    = 1'b1;
      redirect_pc = 32'h46;
      tick();
      redirect = 1'b0;
      check("mis_pulse", 32'(misalign_err), 32'd1);
      check("mis_addr", instr_rAddr, 32'h44);
      check("mis_valid", 32'(id_valid), 32'd0);
      push_exp(32'h44);
      tick();
      check("mis_pulse_end", 32'(misalign_err), 32'd0);
      take_head("mis");

      // PC wrap
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      check("wrap_valid", 32'(id_valid), 32'd0);
      push_exp(32'hFFFF_FFFC);
      push_exp(32'h0);
      tick();
      take_head("wrap0");
      tick();
      take_head("wrap1");

      // Back-to-back redirects: last wins, nothing valid between
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      tick();
      check("b2b_valid0", 32'(id_valid), 32'd0);
      redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      check("b2b_valid1", 32'(id_valid), 32'd0);
      check("b2b_addr", instr_rAddr, 32'h200);
      push_exp(32'h200);
      tick();
      take_head("b2b");

      // Mid-stream asynchronous reset
      id_ready = 1'b0;
      tick();
      tick();
      tick();
      check("mid_count", 32'(dut.count), 32'd2);
      #2;
      reset = 1'b1;
      #1;
      check("mid_valid", 32'(id_valid), 32'd0);
      check("mid_instr", id_instr, 32'h0000_0013);
      check("mid_pc", id_pc, 32'h0);
      check("mid_addr", instr_rAddr, 32'h0);
      #1;
      reset = 1'b0;
      exp_q.delete();
      push_exp(32'h0);
      id_ready = 1'b1;
      tick();
      take_head("mid_first");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
